// File: rtl/l1c_refill_arbiter.sv
// l1c_refill_arbiter: shares one AXI4 read master between the L1 I-cache and D-cache refill paths.
// Each refill is one AR handshake followed by its full R burst; simultaneous requests alternate.
module l1c_refill_arbiter #(
  parameter logic [3:0] ID_I  = 4'd0,
  parameter logic [3:0] ID_D  = 4'd1,
  parameter int         LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             i_req,
  input  logic [31:0]      i_addr,
  input  logic [LEN_W-1:0] i_len,
  output logic             i_ack,
  output logic [31:0]      i_rdata,
  output logic             i_rvalid,
  output logic             i_rlast,

  input  logic             d_req,
  input  logic [31:0]      d_addr,
  input  logic [LEN_W-1:0] d_len,
  output logic             d_ack,
  output logic [31:0]      d_rdata,
  output logic             d_rvalid,
  output logic             d_rlast,

  output logic [3:0]       ARID_M,
  output logic [31:0]      ARADDR_M,
  output logic [LEN_W-1:0] ARLEN_M,
  output logic [2:0]       ARSIZE_M,
  output logic [1:0]       ARBURST_M,
  output logic             ARVALID_M,
  input  logic             ARREADY_M,

  input  logic [3:0]       RID_M,
  input  logic [31:0]      RDATA_M,
  input  logic [1:0]       RRESP_M,
  input  logic             RLAST_M,
  input  logic             RVALID_M,
  output logic             RREADY_M,

  output logic             busy,
  output logic             rd_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t           state, state_nxt;
  logic             owner, owner_nxt;
  logic             last_grant, last_grant_nxt;
  logic [31:0]      araddr_nxt;
  logic [LEN_W-1:0] arlen_nxt;
  logic [3:0]       arid_nxt;
  logic [LEN_W-1:0] beat_cnt, beat_cnt_nxt;
  logic             grant_i, grant_d;
  logic             beat, beat_err;

  assign ARSIZE_M  = 3'b010;
  assign ARBURST_M = 2'b01;
  assign i_rdata   = RDATA_M;
  assign d_rdata   = RDATA_M;
  assign busy      = (state != IDLE);

  // A lone request always wins; on a tie the side that did not win last time goes.
  assign grant_i = i_req & (~d_req | (last_grant == OWN_D));
  assign grant_d = d_req & (~i_req | (last_grant == OWN_I));

  // beat_cnt holds the index of the beat currently on the bus, so it must equal ARLEN exactly on RLAST.
  assign beat     = (state == DATA) & RVALID_M;
  assign beat_err = (RRESP_M != 2'b00) | (RID_M != ARID_M)
                  | (RLAST_M & (beat_cnt != ARLEN_M))
                  | (~RLAST_M & (beat_cnt == ARLEN_M));
  assign rd_err   = beat & beat_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_I;
      last_grant <= OWN_D;
      ARADDR_M   <= '0;
      ARLEN_M    <= '0;
      ARID_M     <= '0;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      ARADDR_M   <= araddr_nxt;
      ARLEN_M    <= arlen_nxt;
      ARID_M     <= arid_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    araddr_nxt     = ARADDR_M;
    arlen_nxt      = ARLEN_M;
    arid_nxt       = ARID_M;
    beat_cnt_nxt   = beat_cnt;
    ARVALID_M      = 1'b0;
    RREADY_M       = 1'b0;
    i_ack          = 1'b0;
    d_ack          = 1'b0;
    i_rvalid       = 1'b0;
    i_rlast        = 1'b0;
    d_rvalid       = 1'b0;
    d_rlast        = 1'b0;

    case (state)
      IDLE: begin
        if (grant_i | grant_d) begin
          owner_nxt  = grant_d ? OWN_D : OWN_I;
          araddr_nxt = grant_d ? d_addr : i_addr;
          arlen_nxt  = grant_d ? d_len : i_len;
          arid_nxt   = grant_d ? ID_D : ID_I;
          state_nxt  = ADDR;
        end
      end

      ADDR: begin
        ARVALID_M = 1'b1;
        if (ARREADY_M) begin
          i_ack          = (owner == OWN_I);
          d_ack          = (owner == OWN_D);
          last_grant_nxt = owner;
          beat_cnt_nxt   = '0;
          state_nxt      = DATA;
        end
      end

      DATA: begin
        // RREADY depends on state alone so it never loops back through RVALID.
        RREADY_M = 1'b1;
        i_rvalid = beat & (owner == OWN_I);
        d_rvalid = beat & (owner == OWN_D);
        i_rlast  = beat & RLAST_M & (owner == OWN_I);
        d_rlast  = beat & RLAST_M & (owner == OWN_D);
        if (RVALID_M) begin
          beat_cnt_nxt = beat_cnt + LEN_W'(1);
          if (RLAST_M) state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
